// File: rtl/syn_s_info.sv
// Slave-side receiver for the UTC-second info link: deserialises four MSB-first
// bytes from rx_info, publishes the 32-bit second and flags frame/gap/sequence errors.
module syn_s_info #(
  parameter int GAP_BITS = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        rx_info,
  input  logic [19:0] tbit_period,
  output logic [31:0] utc_sec,
  output logic        fire_utc,
  output logic        err_frame,
  output logic        err_gap,
  output logic        err_seq
);

  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic          sync1, rx_s;
  logic [19:0]   timer;
  logic [19:0]   half;
  logic          expired;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    shreg;
  logic [31:0]   word;
  logic [GW-1:0] gap_cnt;
  logic          have_prev;

  logic ld_half, ld_full, do_shift, store, cnt_inc, cnt_clr;
  logic gap_inc, gap_clr, fire, e_frame, e_gap;

  assign half    = {1'b0, tbit_period[19:1]};
  assign expired = (timer <= 20'd1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_info;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A falling edge in S_GAP is checked before the gap timeout, so the edge wins a tie.
  always_comb begin
    state_nxt = state;
    ld_half   = 1'b0;
    ld_full   = 1'b0;
    do_shift  = 1'b0;
    store     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    gap_inc   = 1'b0;
    gap_clr   = 1'b0;
    fire      = 1'b0;
    e_frame   = 1'b0;
    e_gap     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          ld_half   = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (expired) begin
          if (!rx_s) begin
            ld_full   = 1'b1;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (expired) begin
          do_shift = 1'b1;
          ld_full  = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (expired) begin
          if (!rx_s) begin
            e_frame   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            store = 1'b1;
            if (byte_cnt == 2'd3) begin
              state_nxt = S_DONE;
            end else begin
              cnt_inc   = 1'b1;
              gap_clr   = 1'b1;
              ld_full   = 1'b1;
              state_nxt = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (!rx_s) begin
          ld_half   = 1'b1;
          state_nxt = S_START;
        end else if (expired) begin
          if (gap_cnt == GAP_LAST) begin
            e_gap     = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            gap_inc = 1'b1;
            ld_full = 1'b1;
          end
        end
      end
      S_DONE: begin
        fire      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered output pulses; utc_sec only moves on a completed frame.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      word      <= '0;
      gap_cnt   <= '0;
      utc_sec   <= '0;
      fire_utc  <= 1'b0;
      err_frame <= 1'b0;
      err_gap   <= 1'b0;
      err_seq   <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      fire_utc  <= fire;
      err_frame <= e_frame;
      err_gap   <= e_gap;
      err_seq   <= fire && have_prev && (word != utc_sec + 32'd1);

      if (ld_half)            timer <= half;
      else if (ld_full)       timer <= tbit_period;
      else if (timer != '0)   timer <= timer - 20'd1;

      if (ld_half) begin
        bit_cnt <= '0;
      end else if (do_shift) begin
        shreg   <= {shreg[6:0], rx_s};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (store) word <= {word[23:0], shreg};

      if (cnt_clr)      byte_cnt <= '0;
      else if (cnt_inc) byte_cnt <= byte_cnt + 2'd1;

      if (gap_clr)      gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + GW'(1);

      if (fire) begin
        utc_sec   <= word;
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_syn_s_info.sv
// Randomised self-checking bench for syn_s_info with a frame-level reference model.
module tb_syn_s_info;

  localparam int T = 10;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rx_info = 1'b1;
  logic [19:0] tbit_period = 20'(T);
  logic [31:0] utc_sec;
  logic        fire_utc, err_frame, err_gap, err_seq;

  int n_cmp = 0;
  int n_bad = 0;

  int          fire_cnt = 0, frame_cnt = 0, gap_cnt = 0, stray_seq = 0;
  logic [31:0] last_utc = '0;
  logic        last_seq = 1'b0;

  logic [31:0] m_utc  = '0;
  logic        m_have = 1'b0;

  syn_s_info #(.GAP_BITS(16)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .rx_info(rx_info), .tbit_period(tbit_period),
    .utc_sec(utc_sec), .fire_utc(fire_utc), .err_frame(err_frame),
    .err_gap(err_gap), .err_seq(err_seq)
  );

  always #5 clk_sys = ~clk_sys;

  // Pulse monitor samples on the falling edge, away from the active edge.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (fire_utc) begin
        fire_cnt <= fire_cnt + 1;
        last_utc <= utc_sec;
        last_seq <= err_seq;
      end
      if (err_seq && !fire_utc) stray_seq <= stray_seq + 1;
      if (err_frame) frame_cnt <= frame_cnt + 1;
      if (err_gap)   gap_cnt   <= gap_cnt + 1;
    end
  end

  // Reference: a new value is out of sequence unless it is the previous good value + 1 mod 2^32.
  task automatic model_frame(input logic [31:0] v, output logic seq);
    seq    = m_have && (64'(v) != ((64'(m_utc) + 64'd1) % 64'h1_0000_0000));
    m_utc  = v;
    m_have = 1'b1;
  endtask

  task automatic bit_time(input logic v);
    rx_info = v;
    repeat (T) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int idle_bits);
    bit_time(1'b0);
    for (int i = 7; i >= 0; i--) bit_time(b[i]);
    bit_time(stop_ok);
    for (int i = 0; i < idle_bits; i++) bit_time(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] v);
    send_byte(v[31:24], 1'b1, int'($urandom_range(0, 3)));
    send_byte(v[23:16], 1'b1, int'($urandom_range(0, 3)));
    send_byte(v[15:8],  1'b1, int'($urandom_range(0, 3)));
    send_byte(v[7:0],   1'b1, 2);
    repeat (20) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_info = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    n_cmp++; if (utc_sec !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_utc: got %h want 00000000", utc_sec); end
    n_cmp++; if (fire_utc !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fire: got %b want 0", fire_utc); end
    n_cmp++; if ({err_frame, err_gap, err_seq} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 000", {err_frame, err_gap, err_seq}); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_first_frame;
    int   f0;
    logic es;
    f0 = fire_cnt;
    send_frame(32'h0000_5511);
    model_frame(32'h0000_5511, es);
    n_cmp++; if (fire_cnt - f0 !== 1) begin n_bad++; $display("[TB] FAIL first_fire_count: got %0d want 1", fire_cnt - f0); end
    n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL first_utc: got %h want %h", last_utc, m_utc); end
    n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL first_seq: got %b want %b", last_seq, es); end
  endtask

  task automatic test_sequence;
    logic [31:0] vals [3] = '{32'h0000_5512, 32'h0000_5520, 32'h0000_5521};
    int   f0;
    logic es;
    foreach (vals[i]) begin
      f0 = fire_cnt;
      send_frame(vals[i]);
      model_frame(vals[i], es);
      n_cmp++; if (fire_cnt - f0 !== 1) begin n_bad++; $display("[TB] FAIL seq_fire_count[%0d]: got %0d want 1", i, fire_cnt - f0); end
      n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL seq_utc[%0d]: got %h want %h", i, last_utc, m_utc); end
      n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL seq_flag[%0d]: got %b want %b", i, last_seq, es); end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] vals [2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    logic es;
    foreach (vals[i]) begin
      send_frame(vals[i]);
      model_frame(vals[i], es);
      n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL wrap_utc[%0d]: got %h want %h", i, last_utc, m_utc); end
      n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL wrap_seq[%0d]: got %b want %b", i, last_seq, es); end
    end
  endtask

  task automatic test_random;
    logic [31:0] v;
    int   f0;
    logic es;
    for (int i = 0; i < 6; i++) begin
      v  = ($urandom_range(0, 1) == 1) ? m_utc + 32'd1 : 32'($urandom);
      f0 = fire_cnt;
      send_frame(v);
      model_frame(v, es);
      n_cmp++; if (fire_cnt - f0 !== 1) begin n_bad++; $display("[TB] FAIL rand_fire_count[%0d]: got %0d want 1", i, fire_cnt - f0); end
      n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL rand_utc[%0d]: got %h want %h", i, last_utc, m_utc); end
      n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL rand_seq[%0d]: got %b want %b", i, last_seq, es); end
    end
  endtask

  task automatic test_frame_error;
    logic [31:0] v;
    int   f0, e0, g0;
    logic es;
    v  = m_utc + 32'd1;
    f0 = fire_cnt; e0 = frame_cnt; g0 = gap_cnt;
    send_byte(v[31:24], 1'b1, 0);
    send_byte(v[23:16], 1'b1, 0);
    send_byte(v[15:8],  1'b0, 3);
    repeat (20) @(posedge clk_sys);
    #1;
    n_cmp++; if (frame_cnt - e0 !== 1) begin n_bad++; $display("[TB] FAIL frame_err_count: got %0d want 1", frame_cnt - e0); end
    n_cmp++; if (fire_cnt - f0 !== 0) begin n_bad++; $display("[TB] FAIL frame_err_fire: got %0d want 0", fire_cnt - f0); end
    n_cmp++; if (gap_cnt - g0 !== 0) begin n_bad++; $display("[TB] FAIL frame_err_gap: got %0d want 0", gap_cnt - g0); end
    n_cmp++; if (utc_sec !== m_utc) begin n_bad++; $display("[TB] FAIL frame_err_utc_hold: got %h want %h", utc_sec, m_utc); end
    send_frame(v);
    model_frame(v, es);
    n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL frame_err_recover_utc: got %h want %h", last_utc, m_utc); end
    n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL frame_err_recover_seq: got %b want %b", last_seq, es); end
  endtask

  task automatic test_gap;
    logic [31:0] v;
    int   f0, e0, g0;
    logic es;
    v  = m_utc + 32'd1;
    f0 = fire_cnt; e0 = frame_cnt; g0 = gap_cnt;
    send_byte(v[31:24], 1'b1, 0);
    send_byte(v[23:16], 1'b1, 20);
    n_cmp++; if (gap_cnt - g0 !== 1) begin n_bad++; $display("[TB] FAIL gap_err_count: got %0d want 1", gap_cnt - g0); end
    n_cmp++; if (fire_cnt - f0 !== 0) begin n_bad++; $display("[TB] FAIL gap_err_fire: got %0d want 0", fire_cnt - f0); end
    n_cmp++; if (frame_cnt - e0 !== 0) begin n_bad++; $display("[TB] FAIL gap_err_frame: got %0d want 0", frame_cnt - e0); end
    n_cmp++; if (utc_sec !== m_utc) begin n_bad++; $display("[TB] FAIL gap_err_utc_hold: got %h want %h", utc_sec, m_utc); end
    send_frame(v);
    model_frame(v, es);
    n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL gap_recover_utc: got %h want %h", last_utc, m_utc); end
    n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL gap_recover_seq: got %b want %b", last_seq, es); end
  endtask

  task automatic test_glitch_reset;
    int   f0, e0, g0;
    logic es;
    f0 = fire_cnt; e0 = frame_cnt; g0 = gap_cnt;
    rx_info = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    rx_info = 1'b1;
    repeat (3 * T) @(posedge clk_sys);
    #1;
    n_cmp++; if ({fire_cnt - f0, frame_cnt - e0, gap_cnt - g0} !== {32'd0, 32'd0, 32'd0}) begin
      n_bad++; $display("[TB] FAIL glitch_pulses: got fire=%0d frame=%0d gap=%0d want 0/0/0", fire_cnt - f0, frame_cnt - e0, gap_cnt - g0);
    end
    n_cmp++; if (utc_sec !== m_utc) begin n_bad++; $display("[TB] FAIL glitch_utc_hold: got %h want %h", utc_sec, m_utc); end

    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h3C, 1'b1, 0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst_n = 1'b0;
    m_utc  = '0;
    m_have = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    n_cmp++; if (utc_sec !== 32'h0) begin n_bad++; $display("[TB] FAIL midframe_reset_utc: got %h want 00000000", utc_sec); end
    n_cmp++; if ({fire_utc, err_frame, err_gap, err_seq} !== 4'b0000) begin n_bad++; $display("[TB] FAIL midframe_reset_pulses: got %b want 0000", {fire_utc, err_frame, err_gap, err_seq}); end
    rx_info = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    repeat (2 * T) @(posedge clk_sys);
    #1;
    f0 = fire_cnt;
    send_frame(32'h0BAD_F00D);
    model_frame(32'h0BAD_F00D, es);
    n_cmp++; if (fire_cnt - f0 !== 1) begin n_bad++; $display("[TB] FAIL post_reset_fire_count: got %0d want 1", fire_cnt - f0); end
    n_cmp++; if (last_utc !== m_utc) begin n_bad++; $display("[TB] FAIL post_reset_utc: got %h want %h", last_utc, m_utc); end
    n_cmp++; if (last_seq !== es) begin n_bad++; $display("[TB] FAIL post_reset_seq: got %b want %b", last_seq, es); end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_sequence();
    test_wrap();
    test_random();
    test_frame_error();
    test_gap();
    test_glitch_reset();
    n_cmp++; if (stray_seq !== 0) begin n_bad++; $display("[TB] FAIL seq_coincident: got %0d stray err_seq pulses want 0", stray_seq); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
